cfar_gate_detect: RTL and testbench

- Upstream feed stage of the CFAR threshold loop.
- Produces the per-sample hit bits, sample-qualifier enable and per-PRI start strobe that the CFAR adaptation stage consumes.
- Synchronises the radar sync pulse (synclk) into the clk domain and opens a programmable range gate after a programmable delay.
- Compares each valid sample inside the gate against the current threshold (door) fed back from the CFAR stage; also counts hits per PRI for monitoring.

---
 rtl/cfar_gate_detect_pkg.sv | 28 ++
 rtl/cfar_gate_detect_sync_edge_det.sv | 27 ++
 rtl/cfar_gate_detect.sv | 108 ++++++++++
 tb/tb_cfar_gate_detect.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cfar_gate_detect_pkg.sv
// Constants and types shared by the CFAR gate/detect front end and the CFAR
// adaptation stage: default widths, default gate settings and FSM encoding.
package cfar_pkg;

  localparam int DW_DEF = 16;
  localparam int CW_DEF = 8;
  localparam int HW_DEF = 16;

  localparam logic [7:0] GATE_DELAY_DEF = 8'd39;
  localparam logic [7:0] PULSES_DEF     = 8'd99;

  // One-hot gate FSM encoding.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_DELAY = 3'b010,
    ST_GATE  = 3'b100
  } gate_state_t;

  // State entered after a PRI start: skip DELAY when no delay is programmed,
  // skip the gate entirely when its length is zero.
  function automatic gate_state_t first_state(input logic delay_nz,
                                              input logic len_nz);
    if (delay_nz)    return ST_DELAY;
    else if (len_nz) return ST_GATE;
    else             return ST_IDLE;
  endfunction

endpackage

// File: rtl/cfar_gate_detect_sync_edge_det.sv
// Three-flop synchroniser for an asynchronous strobe with a one-clock pulse on
// each rising edge. A level held high produces only one pulse.
module sync_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic pulse_o
);

  logic s1_q, s2_q, s3_q;

  // Shift the async level through the synchroniser chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= async_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign pulse_o = s2_q & ~s3_q;

endmodule

// File: rtl/cfar_gate_detect.sv
// CFAR feed stage: synchronises the PRI sync, runs a delay/range-gate FSM and
// emits registered per-sample enable and hit bits plus a per-gate hit count.
// Valid/ready note: there is no back-pressure; enable qualifies bits for one
// clock, and a beat is consumed whenever enable is high.
module cfar_gate_detect
  import cfar_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF,
  parameter int HW = HW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          synclk,
  input  logic [DW-1:0] sample,
  input  logic          sample_valid,
  input  logic [DW-1:0] door,
  input  logic [CW-1:0] gate_delay,
  input  logic [CW-1:0] gate_len,
  output logic          start,
  output logic          enable,
  output logic          bits,
  output logic [HW-1:0] hit_count,
  output logic          overrun,
  output gate_state_t   dbg_state
);

  gate_state_t   state_q;
  logic [CW-1:0] cnt_q;
  logic [HW-1:0] acc_q;
  logic [HW-1:0] acc_next;
  logic [HW-1:0] hit_count_q;
  logic          start_q, enable_q, bits_q, overrun_q;
  logic          sync_pulse;
  logic          gate_open, hit_now, last_delay, last_gate;

  sync_edge_det u_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (synclk),
    .pulse_o (sync_pulse)
  );

  assign gate_open  = (state_q == ST_GATE);
  assign hit_now    = gate_open & sample_valid & (sample >= door);
  assign last_delay = (cnt_q == gate_delay - CW'(1));
  assign last_gate  = (cnt_q == gate_len - CW'(1));
  // Hit accumulator saturates rather than wrapping.
  assign acc_next   = (hit_now && (acc_q != '1)) ? acc_q + HW'(1) : acc_q;

  // Gate FSM with registered strobes; a sync pulse restarts from any state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      hit_count_q <= '0;
      start_q     <= 1'b0;
      enable_q    <= 1'b0;
      bits_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      start_q  <= 1'b0;
      enable_q <= gate_open & sample_valid;
      bits_q   <= hit_now;
      if (sync_pulse) begin
        start_q <= 1'b1;
        cnt_q   <= '0;
        acc_q   <= '0;
        state_q <= first_state(gate_delay != '0, gate_len != '0);
        // Aborting an open delay or gate leaves hit_count untouched.
        if (state_q != ST_IDLE) overrun_q <= 1'b1;
      end else begin
        unique case (state_q)
          ST_DELAY: begin
            if (last_delay) begin
              cnt_q   <= '0;
              state_q <= (gate_len != '0) ? ST_GATE : ST_IDLE;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          ST_GATE: begin
            acc_q <= acc_next;
            if (last_gate) begin
              cnt_q       <= '0;
              state_q     <= ST_IDLE;
              hit_count_q <= acc_next;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          default: begin
            cnt_q <= '0;
          end
        endcase
      end
    end
  end

  assign start     = start_q;
  assign enable    = enable_q;
  assign bits      = bits_q;
  assign hit_count = hit_count_q;
  assign overrun   = overrun_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cfar_gate_detect.sv
// Directed bench for cfar_gate_detect. A timing model of the range gate pushes
// the expected hit bit of every in-gate valid sample; the monitor pops one per
// enable beat.
module tb_cfar_gate_detect;
  import cfar_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        synclk = 1'b0;
  logic [15:0] sample = '0;
  logic        sample_valid = 1'b0;
  logic [15:0] door = '0;
  logic [7:0]  gate_delay = '0;
  logic [7:0]  gate_len = '0;
  logic        start, enable, bits, overrun;
  logic [15:0] hit_count;
  gate_state_t dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  cfar_gate_detect dut (
    .clk          (clk),
    .reset        (reset),
    .synclk       (synclk),
    .sample       (sample),
    .sample_valid (sample_valid),
    .door         (door),
    .gate_delay   (gate_delay),
    .gate_len     (gate_len),
    .start        (start),
    .enable       (enable),
    .bits         (bits),
    .hit_count    (hit_count),
    .overrun      (overrun),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [0:0] exp_q[$];
  int n_chk = 0;
  int n_pass = 0;
  int start_seen = 0, last_start = -1, en_cnt = 0, first_en = -1, bits_cnt = 0;
  int n_push = 0;
  int cur_lo = 1, cur_hi = 0, prev_lo = 1, prev_hi = 0, sync_cyc = 0;
  logic prev_sy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic clr_stats();
    start_seen = 0; last_start = -1; en_cnt = 0; first_en = -1; bits_cnt = 0; n_push = 0;
  endtask

  // ---------------- driver ----------------
  // Drive one cycle of inputs; model the gate window from the sync edge.
  task automatic step(input logic sy, input logic v, input logic [15:0] s, input logic [15:0] d);
    int c;
    @(posedge clk); #1;
    synclk = sy; sample_valid = v; sample = s; door = d;
    c = cyc;
    if (sy && !prev_sy) begin
      prev_lo = cur_lo;
      prev_hi = (cur_hi < c + 2) ? cur_hi : c + 2;
      cur_lo  = c + 3 + int'(gate_delay);
      cur_hi  = cur_lo + int'(gate_len) - 1;
      sync_cyc = c;
    end
    prev_sy = sy;
    if (v && ((c >= cur_lo && c <= cur_hi) || (c >= prev_lo && c <= prev_hi))) begin
      exp_q.push_back(1'(s >= d));
      n_push++;
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (start) begin
        start_seen++;
        last_start = cyc;
      end
      if (enable) begin
        en_cnt++;
        if (first_en < 0) first_en = cyc;
        if (bits) bits_cnt++;
        if (exp_q.size() == 0) chk("unexpected_enable", 32'(enable), 32'd0);
        else chk("bits", 32'(bits), 32'(exp_q.pop_front()));
      end else if (bits) begin
        chk("bits_without_enable", 32'(bits), 32'd0);
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [15:0] s;
    int idx;

    // Reset / idle
    repeat (5) @(posedge clk);
    #1;
    chk("rst_start", 32'(start), 0);
    chk("rst_enable", 32'(enable), 0);
    chk("rst_bits", 32'(bits), 0);
    chk("rst_hit_count", 32'(hit_count), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    reset = 1'b0;
    clr_stats();
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 16'd500, 16'd1);
    chk("idle_no_start", start_seen, 0);
    chk("idle_no_enable", en_cnt, 0);

    // Basic gate: delay 4, length 6, every sample a hit
    gate_delay = 8'd4; gate_len = 8'd6; clr_stats();
    for (int i = 0; i < 24; i++) step(i < 3, 1'b1, 16'd100, 16'd50);
    chk("basic_starts", start_seen, 1);
    chk("basic_start_cyc", last_start, sync_cyc + 3);
    chk("basic_first_en_ofs", first_en - last_start, 5);
    chk("basic_en_cnt", en_cnt, 6);
    chk("basic_bits_cnt", bits_cnt, 6);
    chk("basic_hit_count", 32'(hit_count), 6);
    chk("basic_q_drained", exp_q.size(), 0);
    chk("basic_overrun", 32'(overrun), 0);

    // Boundary compare: door 100 against 99,100,101
    gate_delay = 8'd0; gate_len = 8'd3; clr_stats();
    for (int i = 0; i < 16; i++) begin
      idx = (cyc + 1) - cur_lo;
      s = (i >= 3 && idx >= 0 && idx < 3) ? 16'(99 + idx) : 16'd7;
      step(i < 3, 1'b1, s, 16'd100);
    end
    chk("bnd_en_cnt", en_cnt, 3);
    chk("bnd_bits_cnt", bits_cnt, 2);
    chk("bnd_hit_count", 32'(hit_count), 2);
    chk("bnd_q_drained", exp_q.size(), 0);

    // Zero-length gate
    gate_delay = 8'd3; gate_len = 8'd0; clr_stats();
    for (int i = 0; i < 15; i++) step(i < 3, 1'b1, 16'd900, 16'd1);
    chk("zero_starts", start_seen, 1);
    chk("zero_en_cnt", en_cnt, 0);
    chk("zero_hit_count", 32'(hit_count), 2);
    chk("zero_overrun", 32'(overrun), 0);

    // Overrun: second sync edge 10 cycles in, while the gate is open
    gate_delay = 8'd2; gate_len = 8'd20; clr_stats();
    for (int i = 0; i < 46; i++) begin
      step((i < 3) || (i >= 10 && i < 13), 1'b1, 16'd200, 16'd10);
      if (i == 20) begin
        chk("ovr_hold_hit_count", 32'(hit_count), 2);
        chk("ovr_flag", 32'(overrun), 1);
      end
    end
    chk("ovr_starts", start_seen, 2);
    chk("ovr_en_cnt", en_cnt, 28);
    chk("ovr_hit_count", 32'(hit_count), 20);
    chk("ovr_q_drained", exp_q.size(), 0);

    // Gaps in sample_valid, random magnitudes, then reset inside the gate
    gate_delay = 8'd1; gate_len = 8'd10; clr_stats();
    for (int i = 0; i < 10; i++)
      step(i < 3, (i % 3) != 1, 16'($urandom_range(0, 255)), 16'd128);
    @(negedge clk); #1;
    chk("gap_en_cnt", en_cnt, n_push - exp_q.size());
    chk("gap_in_gate", 32'(dbg_state), 32'(ST_GATE));
    chk("gap_overrun_sticky", 32'(overrun), 1);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    cur_lo = 1; cur_hi = 0; prev_lo = 1; prev_hi = 0;
    #1;
    chk("mrst_start", 32'(start), 0);
    chk("mrst_enable", 32'(enable), 0);
    chk("mrst_bits", 32'(bits), 0);
    chk("mrst_hit_count", 32'(hit_count), 0);
    chk("mrst_overrun", 32'(overrun), 0);
    chk("mrst_state", 32'(dbg_state), 32'(ST_IDLE));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    clr_stats();
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 16'd300, 16'd1);
    chk("post_rst_starts", start_seen, 0);
    chk("post_rst_en_cnt", en_cnt, 0);
    chk("post_rst_state", 32'(dbg_state), 32'(ST_IDLE));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
